// File: rtl/aos_softreg_watchdog_pkg.sv
// Shared types for the SoftReg watchdog: MMIO request/response records,
// watchdog defaults and FSM state encoding.
package aos_softreg_watchdog_pkg;

  localparam int AMI_NUM_APPS = 4;

  localparam int          SOFTREG_WDOG_TIMEOUT = 4096;
  localparam logic [63:0] SOFTREG_WDOG_DATA    = 64'hDEAD_DEAD_DEAD_DEAD;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;

  typedef enum logic {WDOG_IDLE, WDOG_WAIT} SoftRegWdogState;

endpackage

// File: rtl/aos_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module aos_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/aos_softreg_watchdog.sv
// Guards the host MMIO path: forwards requests, tracks the one outstanding
// read and synthesizes a response if the target app never answers.
import aos_softreg_watchdog_pkg::*;

module aos_softreg_watchdog #(
  parameter int          TIMEOUT_CYCLES = SOFTREG_WDOG_TIMEOUT,
  parameter logic [63:0] TIMEOUT_DATA   = SOFTREG_WDOG_DATA,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             app_enable [AMI_NUM_APPS],
  input  SoftRegReq        host_req,
  output SoftRegResp       host_resp,
  output SoftRegReq        os_req,
  input  SoftRegResp       os_resp,
  output logic             timeout_pulse,
  output logic [7:0]       timeout_app,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] stray_cnt,
  output logic [CNT_W-1:0] proto_err_cnt
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [7:0]              app;
  logic [AMI_NUM_APPS-1:0] app_hit;
  logic                    routable;
  logic                    is_rd;
  logic                    is_wr;

  assign app   = host_req.addr[10:3];
  assign is_rd = host_req.valid && !host_req.is_write;
  assign is_wr = host_req.valid &&  host_req.is_write;

  // Out-of-range app selects simply match no enable bit.
  genvar gi;
  generate
    for (gi = 0; gi < AMI_NUM_APPS; gi++) begin : g_hit
      assign app_hit[gi] = (app == 8'(gi)) && app_enable[gi];
    end
  endgenerate
  assign routable = |app_hit;

  SoftRegWdogState state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [7:0]      app_reg, app_next;
  SoftRegReq       os_req_reg, os_req_next;
  SoftRegResp      resp_reg, resp_next;
  logic            pulse_reg, pulse_next;
  logic [7:0]      tapp_reg, tapp_next;
  logic            fwd;
  logic            to_inc;
  logic            stray_inc;
  logic            proto_inc;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    app_next   = app_reg;
    resp_next  = '0;
    pulse_next = 1'b0;
    tapp_next  = tapp_reg;
    fwd        = is_wr && routable;
    to_inc     = 1'b0;
    stray_inc  = 1'b0;
    proto_inc  = 1'b0;

    case (state_reg)
      WDOG_IDLE: begin
        stray_inc = os_resp.valid;
        if (is_rd) begin
          if (routable) begin
            fwd        = 1'b1;
            timer_next = TIMER_LOAD;
            app_next   = app;
            state_next = WDOG_WAIT;
          end else begin
            resp_next.valid = 1'b1;
            resp_next.data  = TIMEOUT_DATA;
          end
        end
      end
      WDOG_WAIT: begin
        proto_inc = is_rd;
        // A real response arriving on the last timer cycle still wins.
        if (os_resp.valid) begin
          resp_next  = os_resp;
          state_next = WDOG_IDLE;
        end else if (timer_reg == '0) begin
          resp_next.valid = 1'b1;
          resp_next.data  = TIMEOUT_DATA;
          pulse_next      = 1'b1;
          tapp_next       = app_reg;
          to_inc          = 1'b1;
          state_next      = WDOG_IDLE;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      default: state_next = WDOG_IDLE;
    endcase

    os_req_next = fwd ? host_req : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= WDOG_IDLE;
      timer_reg  <= '0;
      app_reg    <= '0;
      os_req_reg <= '0;
      resp_reg   <= '0;
      pulse_reg  <= 1'b0;
      tapp_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      app_reg    <= app_next;
      os_req_reg <= os_req_next;
      resp_reg   <= resp_next;
      pulse_reg  <= pulse_next;
      tapp_reg   <= tapp_next;
    end
  end

  assign os_req        = os_req_reg;
  assign host_resp     = resp_reg;
  assign timeout_pulse = pulse_reg;
  assign timeout_app   = tapp_reg;

  aos_sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk(clk), .rst_n(rst_n), .inc(to_inc), .count(timeout_cnt)
  );

  aos_sat_counter #(.W(CNT_W)) u_stray_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stray_inc), .count(stray_cnt)
  );

  aos_sat_counter #(.W(CNT_W)) u_proto_err_cnt (
    .clk(clk), .rst_n(rst_n), .inc(proto_inc), .count(proto_err_cnt)
  );

endmodule
